// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM encoding and default geometry for the instruction cache.
package icache_pkg;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_NUM_LINES  = 16;
  typedef enum logic [2:0] {IC_IDLE, IC_LOOKUP, IC_REFILL_REQ, IC_REFILL_WAIT, IC_RESP} icache_state_t;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: tag/valid/data storage with one write port and async read by index.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 24,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES,
  localparam int OW = $clog2(LINE_WORDS),
  localparam int IW = $clog2(NUM_LINES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_clear_all,
  input  logic                  word_we,
  input  logic [IW-1:0]         wr_index,
  input  logic [OW-1:0]         wr_offset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  tag_we,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  input  logic [IW-1:0]         rd_index,
  input  logic [OW-1:0]         rd_offset,
  output logic                  rd_valid,
  output logic [TAG_WIDTH-1:0]  rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [NUM_LINES-1:0]  valid;
  logic [TAG_WIDTH-1:0]  tags [NUM_LINES];
  logic [DATA_WIDTH-1:0] data [NUM_LINES][LINE_WORDS];
  always_ff @(posedge clk) begin
    if (!rst_n || valid_clear_all) valid <= '0;
    else if (tag_we) valid[wr_index] <= 1'b1;
    if (tag_we) tags[wr_index] <= wr_tag;
    if (word_we) data[wr_index][wr_offset] <= wr_data;
  end
  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index][rd_offset];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache; misses refill a whole line one word per beat.
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_WIDTH - 2 - OW - IW;
  icache_state_t         state;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [OW-1:0]         beat;
  logic [TW-1:0]         rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic flush_pending, rd_valid, hit, going_idle, clear_all, word_we, tag_we, unused_addr_bits;
  assign hit              = rd_valid && rd_tag == addr_q[ADDR_WIDTH-3 -: TW];
  assign going_idle       = (state == IC_LOOKUP && hit) || state == IC_RESP;
  // a flush seen mid-access is deferred until the access has finished installing its line
  assign clear_all        = (state == IC_IDLE && flush) || (going_idle && (flush || flush_pending));
  assign word_we          = state == IC_REFILL_WAIT && mem_resp_valid;
  assign tag_we           = word_we && &beat;
  assign unused_addr_bits = ^req_addr[1:0];
  icache_line_array #(
    .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TW), .LINE_WORDS(LINE_WORDS), .NUM_LINES(NUM_LINES)
  ) u_lines (
    .clk(clk), .rst_n(rst_n), .valid_clear_all(clear_all),
    .word_we(word_we), .wr_index(addr_q[OW +: IW]), .wr_offset(beat), .wr_data(mem_resp_data),
    .tag_we(tag_we), .wr_tag(addr_q[ADDR_WIDTH-3 -: TW]),
    .rd_index(addr_q[OW +: IW]), .rd_offset(addr_q[OW-1:0]),
    .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_data(rd_data)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IC_IDLE;
      addr_q        <= '0;
      beat          <= '0;
      flush_pending <= 1'b0;
      resp_ready    <= 1'b1;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      resp_valid    <= 1'b0;
      flush_pending <= going_idle ? 1'b0 : flush_pending | (flush && state != IC_IDLE);
      case (state)
        IC_IDLE: if (req_valid) begin
          addr_q     <= req_addr[ADDR_WIDTH-1:2];
          resp_ready <= 1'b0;
          state      <= IC_LOOKUP;
        end
        IC_LOOKUP: if (hit) begin
          resp_data  <= rd_data;
          resp_valid <= 1'b1;
          resp_ready <= 1'b1;
          hit_count  <= hit_count + 32'd1;
          state      <= IC_IDLE;
        end else begin
          miss_count    <= miss_count + 32'd1;
          beat          <= '0;
          mem_req_valid <= 1'b1;
          mem_req_addr  <= {addr_q[ADDR_WIDTH-3:OW], {OW{1'b0}}, 2'b00};
          state         <= IC_REFILL_REQ;
        end
        IC_REFILL_REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state         <= IC_REFILL_WAIT;
        end
        IC_REFILL_WAIT: if (mem_resp_valid) begin
          if (&beat) state <= IC_RESP;
          else begin
            beat          <= beat + 1'b1;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {addr_q[ADDR_WIDTH-3:OW], beat + 1'b1, 2'b00};
            state         <= IC_REFILL_REQ;
          end
        end
        IC_RESP: begin
          resp_data  <= rd_data;
          resp_valid <= 1'b1;
          resp_ready <= 1'b1;
          state      <= IC_IDLE;
        end
        default: state <= IC_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized and directed checks of icache against an array-based cache model.
module tb_icache;
  logic        clk = 0, rst_n = 0, req_valid = 0, flush = 0;
  logic [31:0] req_addr = 0;
  logic        resp_ready, resp_valid, mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] resp_data, mem_req_addr, mem_resp_data, hit_count, miss_count;
  int          nvec = 0, errs = 0, stall_cfg = 0;
  bit          spurious_en = 0;
  logic [31:0] req_log [$];
  bit   [15:0] ref_valid;
  logic [23:0] ref_tag [16];
  logic [31:0] exp_hits, exp_misses;

  icache dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .resp_ready(resp_ready), .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // memory: one-cycle response after each handshake, optional ready stall, optional stray responses
  initial begin : mem_model
    bit fire, vld;
    logic [31:0] fa;
    int wait_cnt;
    wait_cnt = 0;
    mem_req_ready = 1; mem_resp_valid = 0; mem_resp_data = 0;
    forever begin
      @(negedge clk);
      vld  = mem_req_valid === 1'b1;
      fire = vld && mem_req_ready;
      fa   = mem_req_addr;
      if (fire) req_log.push_back(fa);
      @(posedge clk); #1;
      if (fire) wait_cnt = 0;
      else if (vld) wait_cnt++;
      mem_req_ready  = wait_cnt >= stall_cfg;
      mem_resp_valid = fire || (spurious_en && $urandom_range(0, 3) == 0);
      mem_resp_data  = fire ? mem_word(fa) : $urandom;
    end
  end

  task automatic model(input logic [31:0] a, input int fl_at, output bit hit);
    int idx;
    idx = int'(a[7:4]);
    if (fl_at == 0) ref_valid = '0;
    hit = ref_valid[idx] && ref_tag[idx] == a[31:8];
    if (hit) exp_hits++;
    else begin
      exp_misses++;
      ref_valid[idx] = 1'b1;
      ref_tag[idx] = a[31:8];
    end
    if (fl_at > 0) ref_valid = '0;
  endtask

  function automatic bit log_ok(input int base, input logic [31:0] a, input bit miss);
    if (req_log.size() != base + (miss ? 4 : 0)) return 0;
    for (int k = 0; k < 4 && miss; k++)
      if (req_log[base+k] !== {a[31:4], 4'(k * 4)}) return 0;
    return 1;
  endfunction

  // one request; flush pulsed in relative cycle fl_at (0 = with the request); lat = -1 on timeout
  task automatic issue(input logic [31:0] a, input int fl_at, output int lat, output logic [31:0] d, output logic dbl);
    lat = -1; d = 'x;
    @(posedge clk); #1;
    req_valid = 1; req_addr = a; flush = fl_at == 0;
    for (int c = 1; c < 400 && lat < 0; c++) begin
      @(posedge clk); #1;
      req_valid = 0; flush = c == fl_at;
      @(negedge clk);
      if (resp_valid) begin lat = c; d = resp_data; end
    end
    flush = 0;
    @(negedge clk);
    dbl = resp_valid;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    nvec++; if ({resp_ready, resp_valid, mem_req_valid} !== 3'b100) begin errs++;
      $display("FAIL reset_ctrl got ready/valid/mem_valid=%b want 100", {resp_ready, resp_valid, mem_req_valid}); end
    nvec++; if (resp_data !== 0 || mem_req_addr !== 0) begin errs++;
      $display("FAIL reset_data got resp_data=%h mem_addr=%h want 0", resp_data, mem_req_addr); end
    nvec++; if (hit_count !== 0 || miss_count !== 0) begin errs++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count); end
    ref_valid = '0; exp_hits = 0; exp_misses = 0;
  endtask

  task automatic test_cold_miss();
    int lat, base; logic [31:0] d; logic dbl; bit hit;
    base = req_log.size();
    issue(32'h0, -1, lat, d, dbl);
    model(32'h0, -1, hit);
    nvec++; if (lat !== 11) begin errs++; $display("FAIL cold_latency got %0d want 11", lat); end
    nvec++; if (d !== 32'h11) begin errs++; $display("FAIL cold_data got %h want 00000011", d); end
    nvec++; if (!log_ok(base, 32'h0, 1)) begin errs++;
      $display("FAIL cold_mem_reqs got %0d requests want 0,4,8,c", req_log.size() - base); end
    nvec++; if (miss_count !== 1 || dbl !== 0) begin errs++;
      $display("FAIL cold_count got miss=%0d dbl=%b want 1 0", miss_count, dbl); end
  endtask

  task automatic test_hit();
    int lat, base, bad; logic [31:0] d; logic dbl; bit hit;
    base = req_log.size();
    issue(32'h8, -1, lat, d, dbl);
    model(32'h8, -1, hit);
    nvec++; if (lat !== 2 || d !== 32'h33) begin errs++;
      $display("FAIL hit_resp got lat=%0d data=%h want 2 00000033", lat, d); end
    nvec++; if (req_log.size() != base || hit_count !== 1) begin errs++;
      $display("FAIL hit_side got mem_reqs=%0d hits=%0d want 0 1", req_log.size() - base, hit_count); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_data !== 32'h33 || resp_valid !== 0) bad++;
    end
    nvec++; if (bad != 0) begin errs++; $display("FAIL hit_hold got %0d bad idle cycles want 0", bad); end
  endtask

  task automatic test_conflict();
    logic [31:0] addrs [2] = '{32'h100, 32'h0};
    int lat; logic [31:0] d; logic dbl; bit hit;
    foreach (addrs[i]) begin
      issue(addrs[i], -1, lat, d, dbl);
      model(addrs[i], -1, hit);
      nvec++; if (lat !== 11 || d !== mem_word(addrs[i])) begin errs++;
        $display("FAIL conflict_miss addr=%h got lat=%0d data=%h want 11 %h", addrs[i], lat, d, mem_word(addrs[i])); end
    end
    nvec++; if (miss_count !== 3 || hit_count !== 1) begin errs++;
      $display("FAIL conflict_counts got miss=%0d hit=%0d want 3 1", miss_count, hit_count); end
  endtask

  task automatic test_flush();
    logic [31:0] addrs [6] = '{32'h4, 32'h4, 32'h4, 32'h40, 32'h40, 32'h4};
    int          fls   [6] = '{-1, 0, -1, 5, -1, -1};
    int lat; logic [31:0] d; logic dbl; bit hit;
    @(posedge clk); #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    ref_valid = '0;
    foreach (addrs[i]) begin
      issue(addrs[i], fls[i], lat, d, dbl);
      model(addrs[i], fls[i], hit);
      nvec++; if (lat !== (hit ? 2 : 11) || d !== mem_word(addrs[i])) begin errs++;
        $display("FAIL flush_step%0d addr=%h got lat=%0d data=%h want %0d %h", i, addrs[i], lat, d, hit ? 2 : 11, mem_word(addrs[i])); end
    end
    nvec++; if (hit_count !== exp_hits || miss_count !== exp_misses) begin errs++;
      $display("FAIL flush_counts got %0d/%0d want %0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, pa, d; int lat, base, bad_ready, bad_hold, stalls, extra; logic pv, pr; bit hit;
    a = 32'h210; lat = -1; bad_ready = 0; bad_hold = 0; stalls = 0; extra = 0; pv = 0; pr = 1; pa = 0; d = 'x;
    base = req_log.size();
    model(a, -1, hit);
    stall_cfg = 5;
    @(posedge clk); #1 req_valid = 1; req_addr = a;
    for (int c = 1; c < 400 && lat < 0; c++) begin
      @(posedge clk); #1;
      req_valid = c == 12; req_addr = c == 12 ? 32'h4 : a;
      @(negedge clk);
      if (resp_valid) begin lat = c; d = resp_data; end
      else begin
        if (resp_ready !== 0) bad_ready++;
        if (pv && !pr && (mem_req_valid !== 1 || mem_req_addr !== pa)) bad_hold++;
        if (mem_req_valid === 1 && !mem_req_ready) stalls++;
        pv = mem_req_valid === 1; pr = mem_req_ready; pa = mem_req_addr;
      end
    end
    req_valid = 0;
    stall_cfg = 0;
    repeat (40) begin @(negedge clk); if (resp_valid !== 0) extra++; end
    nvec++; if (lat !== 31 || d !== mem_word(a)) begin errs++;
      $display("FAIL bp_resp got lat=%0d data=%h want 31 %h", lat, d, mem_word(a)); end
    nvec++; if (bad_ready != 0 || bad_hold != 0) begin errs++;
      $display("FAIL bp_stable got ready_violations=%0d hold_violations=%0d want 0 0", bad_ready, bad_hold); end
    nvec++; if (stalls != 20 || !log_ok(base, a, 1)) begin errs++;
      $display("FAIL bp_beats got stall_cycles=%0d mem_reqs=%0d want 20 4", stalls, req_log.size() - base); end
    nvec++; if (extra != 0 || miss_count !== exp_misses) begin errs++;
      $display("FAIL bp_ignored got extra_resps=%0d miss=%0d want 0 %0d", extra, miss_count, exp_misses); end
  endtask

  task automatic test_random();
    logic [31:0] a, d; int lat, base, fl, r; logic dbl; bit hit;
    spurious_en = 1;
    repeat (60) begin
      a = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      fl = r == 0 ? 0 : r == 1 ? 1 : -1;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      base = req_log.size();
      issue(a, fl, lat, d, dbl);
      model(a, fl, hit);
      nvec++; if (lat !== (hit ? 2 : 11)) begin errs++;
        $display("FAIL rnd_latency addr=%h flush=%0d got %0d want %0d", a, fl, lat, hit ? 2 : 11); end
      nvec++; if (d !== mem_word({a[31:2], 2'b00})) begin errs++;
        $display("FAIL rnd_data addr=%h got %h want %h", a, d, mem_word({a[31:2], 2'b00})); end
      nvec++; if (dbl !== 0) begin errs++; $display("FAIL rnd_double addr=%h got resp_valid=%b want 0", a, dbl); end
      nvec++; if (hit_count !== exp_hits || miss_count !== exp_misses) begin errs++;
        $display("FAIL rnd_counts got %0d/%0d want %0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
      nvec++; if (!log_ok(base, a, !hit)) begin errs++;
        $display("FAIL rnd_mem_reqs addr=%h got %0d requests want %0d", a, req_log.size() - base, hit ? 0 : 4); end
    end
    spurious_en = 0;
  endtask

  task automatic test_reset_mid_refill();
    int lat; logic [31:0] d; logic dbl; bit hit;
    @(posedge clk); #1 req_valid = 1; req_addr = 32'h0;
    @(posedge clk); #1 req_valid = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    nvec++; if (mem_req_valid !== 1 || mem_req_addr !== 32'h8) begin errs++;
      $display("FAIL rst_beat2 got valid=%b addr=%h want 1 00000008", mem_req_valid, mem_req_addr); end
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    nvec++; if ({resp_ready, resp_valid, mem_req_valid} !== 3'b100 || hit_count !== 0 || miss_count !== 0) begin errs++;
      $display("FAIL rst_abort got ready/valid/mem_valid=%b counts=%0d/%0d want 100 0/0",
               {resp_ready, resp_valid, mem_req_valid}, hit_count, miss_count); end
    ref_valid = '0; exp_hits = 0; exp_misses = 0;
    issue(32'h0, -1, lat, d, dbl);
    model(32'h0, -1, hit);
    nvec++; if (lat !== 11 || d !== 32'h11 || miss_count !== 1) begin errs++;
      $display("FAIL rst_rerequest got lat=%0d data=%h miss=%0d want 11 00000011 1", lat, d, miss_count); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_backpressure();
    test_random();
    test_reset_mid_refill();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
